// File: rtl/caxi4interconnect_rd_pkg.sv
// caxi4interconnect_rd_pkg
//   Shared definitions for the crossbar read-response path.
//   - Read-steer FSM state encodings (RS_*).
//   - AXI RRESP codes.
//   - Field layout of a read-order FIFO entry: {arlen[7:0], slaveIdx}.
package caxi4interconnect_rd_pkg;

  // Read-steer FSM states
  localparam logic [1:0] RS_IDLE   = 2'd0;
  localparam logic [1:0] RS_ROUTE  = 2'd1;
  localparam logic [1:0] RS_POP    = 2'd2;
  localparam logic [1:0] RS_SETTLE = 2'd3;

  // AXI read response codes
  localparam logic [1:0] RRESP_OKAY   = 2'b00;
  localparam logic [1:0] RRESP_EXOKAY = 2'b01;
  localparam logic [1:0] RRESP_SLVERR = 2'b10;
  localparam logic [1:0] RRESP_DECERR = 2'b11;

  // Order FIFO entry layout: slave index in the low bits, arlen above it
  localparam int ORD_IDX_LSB = 0;
  localparam int ORD_LEN_W   = 8;

  // arlen sits directly above the slave index, whose width is a parameter
  function automatic int ordLenLsb(input int idxW);
    return ORD_IDX_LSB + idxW;
  endfunction

endpackage

// File: rtl/caxi4interconnect_rd_beat_reg.sv
// caxi4interconnect_rd_beat_reg
//   One-deep valid/ready register slice. Holds one beat and accepts a new
//   one in the same cycle the held beat drains, so it sustains 1 beat/cycle.
//   Ports:
//     HCLK       clock
//     fifo_reset asynchronous active-low reset (drops any held beat)
//     inValid    upstream beat valid
//     inReady    upstream ready (slice empty or draining this cycle)
//     inData     upstream beat payload
//     outValid   registered beat valid
//     outReady   downstream ready
//     outData    registered beat payload, stable while outValid & !outReady
module caxi4interconnect_rd_beat_reg #(
  parameter int W = 67
) (
  input  logic         HCLK,
  input  logic         fifo_reset,
  input  logic         inValid,
  output logic         inReady,
  input  logic [W-1:0] inData,
  output logic         outValid,
  input  logic         outReady,
  output logic [W-1:0] outData
);

  assign inReady = !outValid || outReady;

  // Payload only changes on a load, so it stays put while stalled
  always_ff @(posedge HCLK or negedge fifo_reset) begin
    if (!fifo_reset) begin
      outValid <= 1'b0;
      outData  <= '0;
    end else if (inReady) begin
      outValid <= inValid;
      if (inValid) begin
        outData <= inData;
      end
    end
  end

endmodule

// File: rtl/caxi4interconnect_rd_resp_steer.sv
// caxi4interconnect_rd_resp_steer
//   Consumes the read-order FIFO of a crossbar master port: takes the head
//   entry {arlen, slaveIdx}, steers that slave's R channel to the master
//   through a one-deep register slice, and pops the FIFO once the RLAST beat
//   is accepted, so read responses come back in issue order.
//   Optional feature macro: CAXI4_RDSTEER_LEN_CHECK_EN enables a beat counter
//   that pulses lenErr when RLAST does not line up with arlen.
//   Ports:
//     HCLK, fifo_reset           clock, asynchronous active-low reset
//     ordValid, ordData, ordPop  order FIFO head and read strobe
//     slvRValid/Ready/Data/Resp/Last  per-slave R channels (slave s in lane s)
//     mstRValid/Ready/Data/Resp/Last  master R channel, registered outputs
//     lenErr                     beat-count mismatch pulse
module caxi4interconnect_rd_resp_steer
  import caxi4interconnect_rd_pkg::*;
#(
  parameter int NUM_SLAVES = 8,
  parameter int SLV_IDX_W  = 3,
  parameter int DATA_W     = 64,
  parameter int POP_SETTLE = 2
) (
  input  logic                         HCLK,
  input  logic                         fifo_reset,
  input  logic                         ordValid,
  input  logic [8+SLV_IDX_W-1:0]       ordData,
  output logic                         ordPop,
  input  logic [NUM_SLAVES-1:0]        slvRValid,
  output logic [NUM_SLAVES-1:0]        slvRReady,
  input  logic [NUM_SLAVES*DATA_W-1:0] slvRData,
  input  logic [NUM_SLAVES*2-1:0]      slvRResp,
  input  logic [NUM_SLAVES-1:0]        slvRLast,
  output logic                         mstRValid,
  input  logic                         mstRReady,
  output logic [DATA_W-1:0]            mstRData,
  output logic [1:0]                   mstRResp,
  output logic                         mstRLast,
  output logic                         lenErr
);

  localparam int LEN_LSB = ordLenLsb(SLV_IDX_W);

  logic [1:0]           state;
  logic [SLV_IDX_W-1:0] selIdx;
  logic [7:0]           settleCnt;

  logic                 selHit;
  logic                 selRValid;
  logic                 selRLast;
  logic [DATA_W-1:0]    selRData;
  logic [1:0]           selRResp;
  logic                 route;
  logic                 beatInReady;
  logic                 accept;

  // Mux the selected slave's R channel. An index with no matching slave
  // leaves selHit low, so nothing can be accepted from it.
  always_comb begin
    selHit    = 1'b0;
    selRValid = 1'b0;
    selRLast  = 1'b0;
    selRData  = '0;
    selRResp  = '0;
    for (int s = 0; s < NUM_SLAVES; s++) begin
      if (selIdx == SLV_IDX_W'(s)) begin
        selHit    = 1'b1;
        selRValid = slvRValid[s];
        selRLast  = slvRLast[s];
        selRData  = slvRData[s*DATA_W +: DATA_W];
        selRResp  = slvRResp[s*2 +: 2];
      end
    end
  end

  assign route  = (state == RS_ROUTE);
  assign accept = route && selHit && selRValid && beatInReady;
  assign ordPop = (state == RS_POP);

  // Only the selected slave ever sees ready; the others are stalled in place
  always_comb begin
    slvRReady = '0;
    for (int s = 0; s < NUM_SLAVES; s++) begin
      if (route && (selIdx == SLV_IDX_W'(s))) begin
        slvRReady[s] = beatInReady;
      end
    end
  end

  // Order FSM. SETTLE covers the FIFO's valid bubble after a pop: ordValid
  // may still show the popped entry, so it is ignored until the count ends.
  always_ff @(posedge HCLK or negedge fifo_reset) begin
    if (!fifo_reset) begin
      state     <= RS_IDLE;
      selIdx    <= '0;
      settleCnt <= '0;
    end else begin
      case (state)
        RS_IDLE: begin
          if (ordValid) begin
            selIdx <= ordData[ORD_IDX_LSB +: SLV_IDX_W];
            state  <= RS_ROUTE;
          end
        end
        RS_ROUTE: begin
          if (accept && selRLast) begin
            state <= RS_POP;
          end
        end
        RS_POP: begin
          settleCnt <= 8'(POP_SETTLE);
          state     <= RS_SETTLE;
        end
        RS_SETTLE: begin
          if (settleCnt <= 8'd1) begin
            settleCnt <= '0;
            state     <= RS_IDLE;
          end else begin
            settleCnt <= settleCnt - 8'd1;
          end
        end
        default: state <= RS_IDLE;
      endcase
    end
  end

  caxi4interconnect_rd_beat_reg #(
    .W(DATA_W + 3)
  ) beatReg (
    .HCLK      (HCLK),
    .fifo_reset(fifo_reset),
    .inValid   (accept),
    .inReady   (beatInReady),
    .inData    ({selRResp, selRLast, selRData}),
    .outValid  (mstRValid),
    .outReady  (mstRReady),
    .outData   ({mstRResp, mstRLast, mstRData})
  );

`ifdef CAXI4_RDSTEER_LEN_CHECK_EN
  logic [7:0] selLen;
  logic [7:0] beatCnt;
  logic       lenErrR;

  // beatCnt is the zero-based index of the beat being accepted, so a
  // well-formed burst carries RLAST exactly when beatCnt equals arlen.
  always_ff @(posedge HCLK or negedge fifo_reset) begin
    if (!fifo_reset) begin
      selLen  <= '0;
      beatCnt <= '0;
      lenErrR <= 1'b0;
    end else begin
      lenErrR <= 1'b0;
      if ((state == RS_IDLE) && ordValid) begin
        selLen  <= ordData[LEN_LSB +: ORD_LEN_W];
        beatCnt <= '0;
      end else if (accept) begin
        beatCnt <= beatCnt + 8'd1;
        lenErrR <= selRLast ? (beatCnt != selLen) : (beatCnt == selLen);
      end
    end
  end

  assign lenErr = lenErrR;
`else
  logic unusedLen;
  assign unusedLen = ^ordData[LEN_LSB +: ORD_LEN_W];
  assign lenErr    = 1'b0;
`endif

endmodule

// File: tb/tb_caxi4interconnect_rd_resp_steer.sv
// tb_caxi4interconnect_rd_resp_steer
//   Directed bench: a cycle-by-cycle vector table (single beat, order pop
//   and settle bubble, backpressured burst) plus hand-written sequences for
//   ordering, beat-count checking, and asynchronous reset mid-burst.
module tb_caxi4interconnect_rd_resp_steer;
  import caxi4interconnect_rd_pkg::*;

  localparam int NS  = 8;
  localparam int IW  = 3;
  localparam int DW  = 64;

  logic              HCLK;
  logic              fifo_reset;
  logic              ordValid;
  logic [8+IW-1:0]   ordData;
  logic              ordPop;
  logic [NS-1:0]     slvRValid;
  logic [NS-1:0]     slvRReady;
  logic [NS*DW-1:0]  slvRData;
  logic [NS*2-1:0]   slvRResp;
  logic [NS-1:0]     slvRLast;
  logic              mstRValid;
  logic              mstRReady;
  logic [DW-1:0]     mstRData;
  logic [1:0]        mstRResp;
  logic              mstRLast;
  logic              lenErr;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] rxQ[$];

  caxi4interconnect_rd_resp_steer #(
    .NUM_SLAVES(NS), .SLV_IDX_W(IW), .DATA_W(DW), .POP_SETTLE(2)
  ) dut (
    .HCLK(HCLK), .fifo_reset(fifo_reset),
    .ordValid(ordValid), .ordData(ordData), .ordPop(ordPop),
    .slvRValid(slvRValid), .slvRReady(slvRReady), .slvRData(slvRData),
    .slvRResp(slvRResp), .slvRLast(slvRLast),
    .mstRValid(mstRValid), .mstRReady(mstRReady), .mstRData(mstRData),
    .mstRResp(mstRResp), .mstRLast(mstRLast), .lenErr(lenErr)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  // Record every beat the master takes
  always @(posedge HCLK) begin
    if (fifo_reset && mstRValid && mstRReady) rxQ.push_back(mstRData);
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic        ordV;
    logic [2:0]  ordIdx;
    logic [7:0]  ordLen;
    int          rvSlave;
    logic [63:0] rData;
    logic [1:0]  rResp;
    logic        rLast;
    logic        mReady;
    logic        expPop;
    logic [7:0]  expRReady;
    logic        expMValid;
    logic [63:0] expMData;
    logic [1:0]  expMResp;
    logic        expMLast;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clearSlaves();
    for (int s = 0; s < NS; s++) begin
      slvRValid[s]          = 1'b0;
      slvRData[s*DW +: DW]  = {32'hDEAD_BEEF, 24'h0, 8'(s)};
      slvRResp[s*2 +: 2]    = RRESP_DECERR;
      slvRLast[s]           = 1'b1;
    end
  endtask

  task automatic driveSlave(input int s, input logic v, input logic [63:0] d,
                            input logic [1:0] r, input logic l);
    slvRValid[s]         = v;
    slvRData[s*DW +: DW] = d;
    slvRResp[s*2 +: 2]   = r;
    slvRLast[s]          = l;
  endtask

  task automatic resetDut();
    fifo_reset = 1'b0;
    ordValid   = 1'b0;
    ordData    = '0;
    mstRReady  = 1'b1;
    clearSlaves();
    repeat (2) @(negedge HCLK);
    fifo_reset = 1'b1;
  endtask

  // Drive one vector at the falling edge; outputs are sampled #1 later
  task automatic applyStimulus(input vec_t v);
    @(negedge HCLK);
    ordValid  = v.ordV;
    ordData   = {v.ordLen, v.ordIdx};
    mstRReady = v.mReady;
    clearSlaves();
    if (v.rvSlave >= 0) driveSlave(v.rvSlave, 1'b1, v.rData, v.rResp, v.rLast);
  endtask

  function automatic vec_t mk(input logic ov, input logic [2:0] oi, input logic [7:0] ol,
                              input int rv, input logic [63:0] rd, input logic [1:0] rr,
                              input logic rl, input logic mr, input logic ep,
                              input logic [7:0] er, input logic emv, input logic [63:0] emd,
                              input logic [1:0] emr, input logic eml);
    vec_t v;
    v.ordV = ov; v.ordIdx = oi; v.ordLen = ol; v.rvSlave = rv; v.rData = rd;
    v.rResp = rr; v.rLast = rl; v.mReady = mr; v.expPop = ep; v.expRReady = er;
    v.expMValid = emv; v.expMData = emd; v.expMResp = emr; v.expMLast = eml;
    return v;
  endfunction

  initial begin
    int popCnt;
    int errCnt;
    bit found;
    logic [63:0] t5Data [3];

    fifo_reset = 1'b1;
    ordValid   = 1'b0;
    ordData    = '0;
    mstRReady  = 1'b1;
    clearSlaves();
    #1;

    // Reset state
    fifo_reset = 1'b0;
    repeat (2) @(negedge HCLK);
    #1;
    checkOutput("rst_ordPop",    64'(ordPop),    64'd0);
    checkOutput("rst_slvRReady", 64'(slvRReady), 64'd0);
    checkOutput("rst_mstRValid", 64'(mstRValid), 64'd0);
    checkOutput("rst_mstRData",  mstRData,       64'd0);
    checkOutput("rst_mstRResp",  64'(mstRResp),  64'd0);
    checkOutput("rst_mstRLast",  64'(mstRLast),  64'd0);
    checkOutput("rst_lenErr",    64'(lenErr),    64'd0);
    fifo_reset = 1'b1;

    // T1 single beat, T4 settle bubble with ordValid held, T2 backpressured burst
    //                 ordV idx  len  slv data      resp          last mRdy pop rReady mV data    resp          last
    vecs.push_back(mk(1, 3'd2, 8'd0, -1, 64'h0,  RRESP_OKAY,   0, 1, 0, 8'h00, 0, 64'h0,  RRESP_OKAY,   0));
    vecs.push_back(mk(1, 3'd2, 8'd0,  2, 64'hA5, RRESP_OKAY,   1, 1, 0, 8'h04, 0, 64'h0,  RRESP_OKAY,   0));
    vecs.push_back(mk(1, 3'd2, 8'd0, -1, 64'h0,  RRESP_OKAY,   0, 1, 1, 8'h00, 1, 64'hA5, RRESP_OKAY,   1));
    vecs.push_back(mk(1, 3'd5, 8'd3, -1, 64'h0,  RRESP_OKAY,   0, 1, 0, 8'h00, 0, 64'h0,  RRESP_OKAY,   0));
    vecs.push_back(mk(1, 3'd5, 8'd3, -1, 64'h0,  RRESP_OKAY,   0, 1, 0, 8'h00, 0, 64'h0,  RRESP_OKAY,   0));
    vecs.push_back(mk(1, 3'd5, 8'd3, -1, 64'h0,  RRESP_OKAY,   0, 1, 0, 8'h00, 0, 64'h0,  RRESP_OKAY,   0));
    vecs.push_back(mk(0, 3'd5, 8'd3,  5, 64'hB0, RRESP_OKAY,   0, 0, 0, 8'h20, 0, 64'h0,  RRESP_OKAY,   0));
    vecs.push_back(mk(0, 3'd5, 8'd3,  5, 64'hB1, RRESP_OKAY,   0, 1, 0, 8'h20, 1, 64'hB0, RRESP_OKAY,   0));
    vecs.push_back(mk(0, 3'd5, 8'd3,  5, 64'hB2, RRESP_SLVERR, 0, 0, 0, 8'h00, 1, 64'hB1, RRESP_OKAY,   0));
    vecs.push_back(mk(0, 3'd5, 8'd3,  5, 64'hB2, RRESP_SLVERR, 0, 1, 0, 8'h20, 1, 64'hB1, RRESP_OKAY,   0));
    vecs.push_back(mk(0, 3'd5, 8'd3,  5, 64'hB3, RRESP_OKAY,   1, 0, 0, 8'h00, 1, 64'hB2, RRESP_SLVERR, 0));
    vecs.push_back(mk(0, 3'd5, 8'd3,  5, 64'hB3, RRESP_OKAY,   1, 1, 0, 8'h20, 1, 64'hB2, RRESP_SLVERR, 0));
    vecs.push_back(mk(0, 3'd5, 8'd3, -1, 64'h0,  RRESP_OKAY,   0, 0, 1, 8'h00, 1, 64'hB3, RRESP_OKAY,   1));
    vecs.push_back(mk(0, 3'd5, 8'd3, -1, 64'h0,  RRESP_OKAY,   0, 1, 0, 8'h00, 1, 64'hB3, RRESP_OKAY,   1));
    vecs.push_back(mk(0, 3'd5, 8'd3, -1, 64'h0,  RRESP_OKAY,   0, 1, 0, 8'h00, 0, 64'h0,  RRESP_OKAY,   0));
    vecs.push_back(mk(0, 3'd5, 8'd3, -1, 64'h0,  RRESP_OKAY,   0, 1, 0, 8'h00, 0, 64'h0,  RRESP_OKAY,   0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("row%0d_ordPop", i),    64'(ordPop),    64'(vecs[i].expPop));
      checkOutput($sformatf("row%0d_slvRReady", i), 64'(slvRReady), 64'(vecs[i].expRReady));
      checkOutput($sformatf("row%0d_mstRValid", i), 64'(mstRValid), 64'(vecs[i].expMValid));
      checkOutput($sformatf("row%0d_lenErr", i),    64'(lenErr),    64'd0);
      if (vecs[i].expMValid) begin
        checkOutput($sformatf("row%0d_mstRData", i), mstRData,      vecs[i].expMData);
        checkOutput($sformatf("row%0d_mstRResp", i), 64'(mstRResp), 64'(vecs[i].expMResp));
        checkOutput($sformatf("row%0d_mstRLast", i), 64'(mstRLast), 64'(vecs[i].expMLast));
      end
    end

    // T3 ordering: slave 0 is valid first but slave 1 was issued first
    resetDut();
    rxQ.delete();
    @(negedge HCLK);
    ordValid = 1'b1;
    ordData  = {8'd1, 3'd1};
    driveSlave(0, 1'b1, 64'hC0, RRESP_OKAY, 1'b1);
    @(negedge HCLK);
    #1;
    checkOutput("t3_stall_a", 64'(slvRReady), 64'h02);
    driveSlave(1, 1'b1, 64'hD0, RRESP_OKAY, 1'b0);
    @(negedge HCLK);
    driveSlave(1, 1'b1, 64'hD1, RRESP_OKAY, 1'b1);
    #1;
    checkOutput("t3_stall_b", 64'(slvRReady), 64'h02);
    @(negedge HCLK);
    driveSlave(1, 1'b0, 64'h0, RRESP_OKAY, 1'b0);
    ordData = {8'd0, 3'd0};
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge HCLK);
      #1;
      if (slvRReady[0]) found = 1'b1;
    end
    checkOutput("t3_slave0_routed", 64'(found), 64'd1);
    @(negedge HCLK);
    ordValid = 1'b0;
    driveSlave(0, 1'b0, 64'h0, RRESP_OKAY, 1'b0);
    repeat (3) @(negedge HCLK);
    checkOutput("t3_beat_count", 64'(rxQ.size()), 64'd3);
    if (rxQ.size() == 3) begin
      checkOutput("t3_beat0", rxQ[0], 64'hD0);
      checkOutput("t3_beat1", rxQ[1], 64'hD1);
      checkOutput("t3_beat2", rxQ[2], 64'hC0);
    end

    // T5 beat-count check: arlen=3 but RLAST on the third beat
    resetDut();
    rxQ.delete();
    t5Data[0] = 64'h60; t5Data[1] = 64'h61; t5Data[2] = 64'h62;
    @(negedge HCLK);
    ordValid = 1'b1;
    ordData  = {8'd3, 3'd6};
    errCnt = 0;
    for (int c = 0; c < 9; c++) begin
      @(negedge HCLK);
      ordValid = 1'b0;
      if (c < 3) driveSlave(6, 1'b1, t5Data[c], RRESP_OKAY, (c == 2));
      else       driveSlave(6, 1'b0, 64'h0, RRESP_OKAY, 1'b0);
      #1;
      if (lenErr) errCnt++;
      if (c == 3) begin
`ifdef CAXI4_RDSTEER_LEN_CHECK_EN
        checkOutput("t5_lenErr_cycle", 64'(lenErr), 64'd1);
`else
        checkOutput("t5_lenErr_cycle", 64'(lenErr), 64'd0);
`endif
      end
    end
`ifdef CAXI4_RDSTEER_LEN_CHECK_EN
    checkOutput("t5_lenErr_pulses", 64'(errCnt), 64'd1);
`else
    checkOutput("t5_lenErr_pulses", 64'(errCnt), 64'd0);
`endif
    checkOutput("t5_beat_count", 64'(rxQ.size()), 64'd3);

    // T6 asynchronous reset with a beat held in the register stage
    resetDut();
    @(negedge HCLK);
    ordValid  = 1'b1;
    ordData   = {8'd3, 3'd3};
    mstRReady = 1'b0;
    @(negedge HCLK);
    ordValid = 1'b0;
    driveSlave(3, 1'b1, 64'hE0, RRESP_OKAY, 1'b0);
    @(negedge HCLK);
    clearSlaves();
    #1;
    checkOutput("t6_held_valid", 64'(mstRValid), 64'd1);
    #2;
    fifo_reset = 1'b0;
    #1;
    checkOutput("t6_async_mstRValid", 64'(mstRValid), 64'd0);
    checkOutput("t6_async_mstRData",  mstRData,       64'd0);
    checkOutput("t6_async_slvRReady", 64'(slvRReady), 64'd0);
    checkOutput("t6_async_ordPop",    64'(ordPop),    64'd0);
    @(negedge HCLK);
    fifo_reset = 1'b1;
    rxQ.delete();
    ordValid  = 1'b1;
    ordData   = {8'd0, 3'd4};
    mstRReady = 1'b1;
    @(negedge HCLK);
    ordValid = 1'b0;
    driveSlave(4, 1'b1, 64'hF0, RRESP_EXOKAY, 1'b1);
    popCnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge HCLK);
      if (c == 0) clearSlaves();
      #1;
      if (ordPop) popCnt++;
    end
    checkOutput("t6_pop_count", 64'(popCnt), 64'd1);
    checkOutput("t6_beat_count", 64'(rxQ.size()), 64'd1);
    if (rxQ.size() == 1) checkOutput("t6_beat0", rxQ[0], 64'hF0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
